cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesizable on-chip trace recorder that sits beside `CPU` and captures its bus/fetch activity (`PC`, `ins`, `DataAdr`, `WriteData`, `ReadData`, `MemWrite`) into a circular buffer. Capture is qualified by a selectable mode and stopped by an address-match trigger plus a programmable post-trigger count. After capture, a read port replays entries oldest-first, replacing per-cycle simulation printouts with hardware-visible history on the FPGA.

## Interface
- `AW`, 32, address/PC width
- `DW`, 32, data/instruction width
- `DEPTH`, 16, entries; power of two, ≥4
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low (0 = in reset)
- `PC` in AW — CPU program counter
- `ins` in DW — current instruction
- `DataAdr` in AW — data-memory address
- `WriteData` in DW — store data
- `ReadData` in DW — load data
- `MemWrite` in 1 — store strobe
- `mode` in 2 — 0 OFF, 1 ALL (every cycle), 2 WRITES (MemWrite=1 only), 3 MATCH (DataAdr==`trig_addr` only)
- `arm` in 1 — one-cycle pulse; clears buffer, enters ARMED
- `trig_addr` in AW — trigger address
- `post_count` in $clog2(DEPTH) — qualifying entries to record after trigger entry
- `rd_en` in 1 — read request
- `rd_idx` in $clog2(DEPTH) — 0 = oldest entry
- `rd_valid` out 1 — read response strobe
- `rd_err` out 1 — with `rd_valid`: `rd_idx` ≥ `count`
- `rd_pc` out AW, `rd_ins` out DW, `rd_addr` out AW, `rd_data` out DW, `rd_we` out 1 — entry fields
- `count` out $clog2(DEPTH)+1 — valid entries, saturates at DEPTH
- `state_o` out 2 — IDLE/ARMED/POST/DONE
- `triggered` out 1 — trigger seen since last arm
- `wrapped` out 1 — buffer overwritten at least once since arm

## Operation
- Qualify `q` = mode ALL: 1; WRITES: `MemWrite`; MATCH: `DataAdr`==`trig_addr`; OFF: 0.
- Entry = {PC, ins, DataAdr, MemWrite ? WriteData : ReadData, MemWrite}.
- States: IDLE → (arm) ARMED. ARMED: each `q` cycle writes entry at `wr_ptr`, `wr_ptr`++ mod DEPTH, `count` saturating++; `wrapped` set when write occurs with `count`==DEPTH. Trigger = `q` & `DataAdr`==`trig_addr` while ARMED: entry written, `triggered`=1, remaining=`post_count`; remaining==0 → DONE, else → POST.
- POST: each `q` cycle writes entry, remaining--; write that brings remaining to 0 → DONE.
- DONE: no writes; holds until `arm`.
- `arm` in any state: `wr_ptr`=0, `count`=0, `triggered`=0, `wrapped`=0, → ARMED; `arm` has priority over same-cycle capture (that cycle not recorded).
- `post_count` sampled at trigger; values ≥DEPTH impossible by width; trigger entry survives because post_count ≤ DEPTH-1.
- Read: accepted only in IDLE or DONE. Physical index = (`count`<DEPTH ? rd_idx : wr_ptr+rd_idx) mod DEPTH. `rd_idx`≥`count` → `rd_err`=1, fields 0. `rd_en` in ARMED/POST → no response (`rd_valid` stays 0).

## Timing
- Reset (async assert, sync-safe deassert inside block): state IDLE, all outputs 0, pointers/counters 0; RAM contents undefined, masked by `count`=0.
- Capture: inputs sampled on rising edge; `count`/`state_o`/`triggered` update same edge.
- Read latency 1: `rd_en` at edge N → `rd_valid`=1 and fields valid for cycle after edge N+1 minus... precisely: registered on edge N+1, held exactly one cycle. Back-to-back `rd_en` gives one response per cycle.
- Trigger with `post_count`=0: DONE visible the cycle after trigger edge.
- Reset mid-capture: immediate IDLE, `count`=0.

## Structure
- Package `cpu_trace_pkg`: `trace_state_t` (IDLE, ARMED, POST, DONE), `trace_mode_t`, parametrised entry struct field order, mode constants.
- Sub-module `trace_ram`: simple dual-port, one write port, synchronous read, DEPTH×(2·AW+2·DW+1), no reset.
- Top holds FSM, pointers, qualify/trigger logic, index translation.

## Test plan
- DEPTH=8, mode ALL, arm, trigger at cycle 3 (`trig_addr`=0x40), `post_count`=2 → DONE after 6 entries, `count`=6, `wrapped`=0, rd_idx 0..5 return cycles 0..5, rd_idx 6 → `rd_err`=1.
- DEPTH=8, mode ALL, 20 cycles before trigger, `post_count`=3 → `count`=8, `wrapped`=1, rd_idx 4 = trigger entry, rd_idx 0 = 4th entry before trigger.
- Mode WRITES, stores to 0x10,0x14,0x40 with loads interleaved, trig 0x40, `post_count`=0 → 3 entries, all `rd_we`=1, data = WriteData.
- `arm` asserted in POST with qualifying cycle → that cycle not recorded, `count`=0, `triggered`=0, ARMED.
- `rd_en` during ARMED → `rd_valid` 0; `rd_en` in DONE → `rd_valid` exactly one cycle later.
- `reset`=0 asserted mid-POST asynchronously (between edges) → outputs 0 immediately, IDLE; after release, `rd_idx` 0 → `rd_err`=1.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU trace recorder: FSM states, capture modes,
// and the packed entry layout (pc, ins, addr, data, we from MSB down).
package cpu_trace_pkg;

   typedef logic [1:0] trace_state_t;

   localparam trace_state_t IDLE  = 2'd0;
   localparam trace_state_t ARMED = 2'd1;
   localparam trace_state_t POST  = 2'd2;
   localparam trace_state_t DONE  = 2'd3;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_ALL    = 2'd1,
      MODE_WRITES = 2'd2,
      MODE_MATCH  = 2'd3
   } trace_mode_t;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

   // Reference layout at default widths; the top mirrors this order
   // with its own AW/DW so RAM words stay bit-compatible.
   typedef struct packed {
      logic [DEF_AW-1:0] pc;
      logic [DEF_DW-1:0] ins;
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] data;
      logic              we;
   } trace_entry_t;

   function automatic int entry_width(input int aw, input int dw);
      return 2 * aw + 2 * dw + 1;
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// CPU snoop bus plus trace read port. The master side is the CPU and
// debug host; the slave side is the trace buffer.
interface cpu_trace_buffer_if #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 16
);
   localparam int IW = $clog2(DEPTH);

   logic [AW-1:0] PC;
   logic [DW-1:0] ins;
   logic [AW-1:0] DataAdr;
   logic [DW-1:0] WriteData;
   logic [DW-1:0] ReadData;
   logic          MemWrite;

   logic          rd_en;
   logic [IW-1:0] rd_idx;
   logic          rd_valid;
   logic          rd_err;
   logic [AW-1:0] rd_pc;
   logic [DW-1:0] rd_ins;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_we;

   modport master (
      output PC, ins, DataAdr, WriteData, ReadData, MemWrite,
      output rd_en, rd_idx,
      input  rd_valid, rd_err, rd_pc, rd_ins, rd_addr, rd_data, rd_we
   );

   modport slave (
      input  PC, ins, DataAdr, WriteData, ReadData, MemWrite,
      input  rd_en, rd_idx,
      output rd_valid, rd_err, rd_pc, rd_ins, rd_addr, rd_data, rd_we
   );

endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: simple dual-port RAM, one write port, registered read.
// No reset; stale words are hidden by the entry count in the top.
module trace_ram #(
   parameter  int W     = 129,
   parameter  int DEPTH = 16,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic          re,
   input  logic [IW-1:0] ra,
   output logic [W-1:0]  rq
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rq <= mem[ra];
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace recorder: mode-qualified capture into a circular buffer,
// address trigger with post-trigger count, oldest-first read port.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   cpu_trace_buffer_if.slave        bus,
   input  logic [1:0]               mode,
   input  logic                     arm,
   input  logic [AW-1:0]            trig_addr,
   input  logic [$clog2(DEPTH)-1:0] post_count,
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state_o,
   output logic                     triggered,
   output logic                     wrapped
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW + 1)'(DEPTH);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] ins;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          we;
   } entry_t;

   localparam int EW = entry_width(AW, DW);

   logic [1:0]    rst_sync;
   logic          rst_n;
   trace_state_t  state;
   trace_mode_t   m;
   logic [IW-1:0] wr_ptr;
   logic [IW-1:0] remaining;
   logic          q;
   logic          hit;
   logic          cap;
   logic          full;
   logic          rd_ok;
   logic          rd_bad;
   logic [IW-1:0] rd_phys;
   logic          rd_valid;
   logic          rd_err;
   logic          show;
   entry_t        wr_entry;
   entry_t        rd_entry;
   logic [EW-1:0] rd_raw;

   // Reset asserts at once but releases two edges later, clean of clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   assign m    = trace_mode_t'(mode);
   assign hit  = bus.DataAdr == trig_addr;
   assign full = count == FULL;

   always_comb begin
      q = 1'b0;
      case (m)
         MODE_ALL:    q = 1'b1;
         MODE_WRITES: q = bus.MemWrite;
         MODE_MATCH:  q = hit;
         default:     q = 1'b0;
      endcase
   end

   assign cap = !arm && q && (state == ARMED || state == POST);

   always_comb begin
      wr_entry = '{
         pc:   bus.PC,
         ins:  bus.ins,
         addr: bus.DataAdr,
         data: bus.MemWrite ? bus.WriteData : bus.ReadData,
         we:   bus.MemWrite
      };
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         triggered <= 1'b0;
         wrapped   <= 1'b0;
      end else if (arm) begin
         state     <= ARMED;
         wr_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         triggered <= 1'b0;
         wrapped   <= 1'b0;
      end else if (cap) begin
         wr_ptr <= wr_ptr + IW'(1);
         if (full) wrapped <= 1'b1;
         else      count   <= count + (IW + 1)'(1);
         unique case (1'b1)
            (state == ARMED) && hit: begin
               triggered <= 1'b1;
               remaining <= post_count;
               state     <= (post_count == '0) ? DONE : POST;
            end
            state == POST: begin
               remaining <= remaining - IW'(1);
               if (remaining == IW'(1)) state <= DONE;
            end
            default: ;
         endcase
      end
   end

   assign state_o = state;

   // Once wrapped, wr_ptr points at the oldest surviving entry.
   assign rd_ok   = bus.rd_en && (state == IDLE || state == DONE);
   assign rd_bad  = {1'b0, bus.rd_idx} >= count;
   assign rd_phys = full ? wr_ptr + bus.rd_idx : bus.rd_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         rd_err   <= rd_ok && rd_bad;
      end
   end

   trace_ram #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk (clk),
      .we  (cap),
      .wa  (wr_ptr),
      .wd  (wr_entry),
      .re  (rd_ok),
      .ra  (rd_phys),
      .rq  (rd_raw)
   );

   assign rd_entry = entry_t'(rd_raw);
   assign show     = rd_valid && !rd_err;

   assign bus.rd_valid = rd_valid;
   assign bus.rd_err   = rd_err;
   assign bus.rd_pc    = show ? rd_entry.pc   : '0;
   assign bus.rd_ins   = show ? rd_entry.ins  : '0;
   assign bus.rd_addr  = show ? rd_entry.addr : '0;
   assign bus.rd_data  = show ? rd_entry.data : '0;
   assign bus.rd_we    = show && rd_entry.we;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer at DEPTH=8: capture, trigger,
// wrap, mode filtering, re-arm, read gating and async reset.
module tb_cpu_trace_buffer;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mode;
   logic        arm;
   logic [31:0] trig_addr;
   logic [2:0]  post_count;
   logic [3:0]  count;
   logic [1:0]  state_o;
   logic        triggered;
   logic        wrapped;

   cpu_trace_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

   cpu_trace_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .mode       (mode),
      .arm        (arm),
      .trig_addr  (trig_addr),
      .post_count (post_count),
      .count      (count),
      .state_o    (state_o),
      .triggered  (triggered),
      .wrapped    (wrapped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  idx;
      logic        err;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
   } vec_t;

   vec_t vt [16];
   int   nv;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] rdd, input logic mw);
      bus.PC        = pc;
      bus.ins       = ins;
      bus.DataAdr   = adr;
      bus.WriteData = wd;
      bus.ReadData  = rdd;
      bus.MemWrite  = mw;
      step();
   endtask

   // Stimulus pattern for cycle i of a run with base b.
   function automatic vec_t mkv(input int b, input int i, input bit t);
      vec_t v;
      v.idx  = '0;
      v.err  = 1'b0;
      v.pc   = 32'(b + 4 * i);
      v.ins  = 32'hA000_0000 + 32'(b + i);
      v.addr = t ? 32'h40 : 32'(b + 32'h800 + 4 * i);
      v.we   = (i % 2) == 1;
      v.data = v.we ? 32'hE000_0000 + 32'(b + i)
                    : 32'hD000_0000 + 32'(b + i);
      return v;
   endfunction

   task automatic drive_gen(input int b, input int i, input bit t);
      vec_t v;
      v = mkv(b, i, t);
      drive(v.pc, v.ins, v.addr, 32'hE000_0000 + 32'(b + i),
            32'hD000_0000 + 32'(b + i), v.we);
   endtask

   function automatic vec_t errv(input int idx);
      vec_t v;
      v.idx  = 3'(idx);
      v.err  = 1'b1;
      v.pc   = '0;
      v.ins  = '0;
      v.addr = '0;
      v.data = '0;
      v.we   = 1'b0;
      return v;
   endfunction

   task automatic run_table(input string tag);
      for (int k = 0; k < nv; k++) begin
         bus.rd_en  = 1'b1;
         bus.rd_idx = vt[k].idx;
         step();
         bus.rd_en  = 1'b0;
         chk($sformatf("%s[%0d] valid", tag, k), 32'(bus.rd_valid), 1);
         chk($sformatf("%s[%0d] err", tag, k), 32'(bus.rd_err),
             32'(vt[k].err));
         chk($sformatf("%s[%0d] pc", tag, k), bus.rd_pc, vt[k].pc);
         chk($sformatf("%s[%0d] ins", tag, k), bus.rd_ins, vt[k].ins);
         chk($sformatf("%s[%0d] addr", tag, k), bus.rd_addr, vt[k].addr);
         chk($sformatf("%s[%0d] data", tag, k), bus.rd_data, vt[k].data);
         chk($sformatf("%s[%0d] we", tag, k), 32'(bus.rd_we),
             32'(vt[k].we));
         step();
         chk($sformatf("%s[%0d] drop", tag, k), 32'(bus.rd_valid), 0);
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      drive(32'hDEAD_0000, 32'h0, 32'h40, 32'h0, 32'h0, 1'b1);
      arm = 1'b0;
   endtask

   initial begin
      mode          = 2'd0;
      arm           = 1'b0;
      trig_addr     = 32'h40;
      post_count    = 3'd0;
      bus.PC        = '0;
      bus.ins       = '0;
      bus.DataAdr   = '0;
      bus.WriteData = '0;
      bus.ReadData  = '0;
      bus.MemWrite  = 1'b0;
      bus.rd_en     = 1'b0;
      bus.rd_idx    = '0;

      step();
      step();
      chk("rst state", 32'(state_o), 0);
      chk("rst count", 32'(count), 0);
      chk("rst trig", 32'(triggered), 0);
      chk("rst wrap", 32'(wrapped), 0);
      chk("rst valid", 32'(bus.rd_valid), 0);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Run 1: trigger at cycle 3, two post entries.
      mode       = 2'd1;
      post_count = 3'd2;
      do_arm();
      chk("t1 armed", 32'(state_o), 1);
      chk("t1 cnt0", 32'(count), 0);
      for (int i = 0; i < 8; i++) begin
         drive_gen(32'h100, i, i == 3);
         if (i == 3) chk("t1 post", 32'(state_o), 2);
         if (i == 2) chk("t1 pre trig", 32'(triggered), 0);
      end
      chk("t1 done", 32'(state_o), 3);
      chk("t1 count", 32'(count), 6);
      chk("t1 trig", 32'(triggered), 1);
      chk("t1 wrap", 32'(wrapped), 0);
      nv = 7;
      for (int k = 0; k < 6; k++) begin
         vt[k] = mkv(32'h100, k, k == 3);
         vt[k].idx = 3'(k);
      end
      vt[6] = errv(6);
      run_table("t1");

      // Run 2: 20 cycles before trigger, ring wraps.
      post_count = 3'd3;
      do_arm();
      for (int i = 0; i < 24; i++) drive_gen(32'h2000, i, i == 20);
      chk("t2 done", 32'(state_o), 3);
      chk("t2 count", 32'(count), 8);
      chk("t2 wrap", 32'(wrapped), 1);
      nv = 8;
      for (int k = 0; k < 8; k++) begin
         vt[k] = mkv(32'h2000, 16 + k, k == 4);
         vt[k].idx = 3'(k);
      end
      run_table("t2");

      // Run 3: stores only; a load to the trigger address is ignored.
      mode       = 2'd2;
      post_count = 3'd0;
      do_arm();
      drive(32'h300, 32'h11, 32'h10, 32'h1111, 32'hBAD0, 1'b1);
      drive(32'h304, 32'h12, 32'h20, 32'h9999, 32'hBAD1, 1'b0);
      drive(32'h308, 32'h13, 32'h14, 32'h2222, 32'hBAD2, 1'b1);
      drive(32'h30C, 32'h14, 32'h40, 32'h9998, 32'hBAD3, 1'b0);
      chk("t3 load no trig", 32'(state_o), 1);
      drive(32'h310, 32'h15, 32'h40, 32'h3333, 32'hBAD4, 1'b1);
      chk("t3 done", 32'(state_o), 3);
      drive(32'h314, 32'h16, 32'h18, 32'h4444, 32'hBAD5, 1'b1);
      chk("t3 count", 32'(count), 3);
      nv = 4;
      vt[0] = '{3'd0, 1'b0, 32'h300, 32'h11, 32'h10, 32'h1111, 1'b1};
      vt[1] = '{3'd1, 1'b0, 32'h308, 32'h13, 32'h14, 32'h2222, 1'b1};
      vt[2] = '{3'd2, 1'b0, 32'h310, 32'h15, 32'h40, 32'h3333, 1'b1};
      vt[3] = errv(3);
      run_table("t3");

      // Run 4: re-arm while in POST, read blocked while ARMED.
      mode       = 2'd1;
      post_count = 3'd5;
      do_arm();
      drive(32'h500, 32'h501, 32'h40, 32'h502, 32'h503, 1'b0);
      chk("t4 post", 32'(state_o), 2);
      drive(32'h504, 32'h505, 32'h80, 32'h506, 32'h507, 1'b0);
      arm = 1'b1;
      drive(32'h508, 32'h509, 32'h40, 32'h50A, 32'h50B, 1'b0);
      arm = 1'b0;
      chk("t4 rearm state", 32'(state_o), 1);
      chk("t4 rearm count", 32'(count), 0);
      chk("t4 rearm trig", 32'(triggered), 0);
      chk("t4 rearm wrap", 32'(wrapped), 0);
      bus.rd_en  = 1'b1;
      bus.rd_idx = 3'd0;
      drive(32'h50C, 32'h50D, 32'h84, 32'h50E, 32'h50F, 1'b0);
      bus.rd_en  = 1'b0;
      chk("t4 armed no rd", 32'(bus.rd_valid), 0);
      post_count = 3'd0;
      drive(32'h510, 32'h511, 32'h40, 32'h512, 32'h513, 1'b0);
      chk("t4 done", 32'(state_o), 3);
      chk("t4 count", 32'(count), 2);
      nv = 3;
      vt[0] = '{3'd0, 1'b0, 32'h50C, 32'h50D, 32'h84, 32'h50F, 1'b0};
      vt[1] = '{3'd1, 1'b0, 32'h510, 32'h511, 32'h40, 32'h513, 1'b0};
      vt[2] = errv(2);
      run_table("t4");

      // Run 5: async reset between edges while in POST.
      post_count = 3'd5;
      do_arm();
      drive(32'h600, 32'h601, 32'h40, 32'h602, 32'h603, 1'b0);
      drive(32'h604, 32'h605, 32'h88, 32'h606, 32'h607, 1'b0);
      chk("t5 post", 32'(state_o), 2);
      #3;
      reset = 1'b0;
      #1;
      chk("t5 async state", 32'(state_o), 0);
      chk("t5 async count", 32'(count), 0);
      chk("t5 async trig", 32'(triggered), 0);
      #2;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("t5 idle", 32'(state_o), 0);
      nv = 1;
      vt[0] = errv(0);
      run_table("t5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
